// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage.
// Two-flop input synchroniser, false-start rejection, sticky framing-error
// flag and a break state that swallows a held-low line.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN -- every sample point becomes
// a 2-of-3 majority over three consecutive synchronised samples; the overall
// frame latency is the same as the single-sample build.

module uart_receiver #(
  parameter int clk_rate  = 9600000,
  parameter int baud_rate = 9600,
  parameter int time_unit = clk_rate / baud_rate
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_finish,
  output logic       rx_busy,
  output logic       frame_error
);

  localparam int HALF = time_unit / 2;
  localparam int CW   = $clog2(time_unit) + 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] BIT_LAST = CW'(time_unit - 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The start decision moves one cycle later to centre the vote window, so
  // the first data bit starts its count one step ahead to keep latency fixed.
  localparam logic [CW-1:0] START_LAST = CW'(HALF);
  localparam logic [CW-1:0] DATA_FIRST = CW'(1);
`else
  localparam logic [CW-1:0] START_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] DATA_FIRST = CW'(0);
`endif

  if (time_unit < 4) begin : g_time_unit_check
    $error("uart_receiver: time_unit (%0d) must be >= 4", time_unit);
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            finish_q, finish_d;
  logic            busy_q, busy_d;
  logic            ferr_q, ferr_d;
  logic            meta_q, meta_d;
  logic            rx_s_q, rx_s_d;
  logic            sample_s;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0]      hist_q, hist_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  // Register stage: synchroniser, FSM state, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      data_q   <= 8'h00;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      hist_q   <= 2'b11;
`endif
    end else begin
      meta_q   <= meta_d;
      rx_s_q   <= rx_s_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
      hist_q   <= hist_d;
`endif
    end
  end

  // Next-state logic: frame sequencing, bit sampling and output updates.
  always_comb begin
    meta_d   = rx;
    rx_s_d   = meta_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    finish_d = 1'b0;
    ferr_d   = ferr_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
    hist_d   = {hist_q[0], rx_s_q};
    sample_s = maj3(hist_q[1], hist_q[0], rx_s_q);
`else
    sample_s = rx_s_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == START_LAST) begin
          if (!sample_s) begin
            state_d = ST_DATA;
            cnt_d   = DATA_FIRST;
            bit_d   = 3'd0;
          end else begin
            // False start: back to idle without touching any output.
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[bit_q] = sample_s;
          cnt_d          = CNT_ZERO;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = CNT_ZERO;
          if (sample_s) begin
            data_d   = shift_q;
            finish_d = 1'b1;
            ferr_d   = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_BREAK: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        bit_d   = 3'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign rx_data     = data_q;
  assign rx_finish   = finish_q;
  assign rx_busy     = busy_q;
  assign frame_error = ferr_q;

endmodule
